dm_port_arbiter: RTL and testbench

Two-port sequencer that shares the single-ported 4 KB big-endian data memory between the CPU load/store unit (port 0) and the I/O/DMA engine (port 1). It arbitrates between requesters round-robin, sequences one word access at a time by driving the memory's `dm_cs`/`dm_rd`/`dm_wr` strobes, captures read data, and returns a one-cycle acknowledge with status. It sits between the requesters and the data memory; no requester drives the memory directly.

---
 rtl/dm_ctrl_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/dm_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_ctrl_pkg
// Description : Shared types and constants for the data-memory port arbiter.
//               Holds the sequencer state encoding, the port indices and the
//               memory bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int PORT_CPU  = 0;
    localparam int PORT_IO   = 1;

    localparam int DM_ADDR_W = 32;
    localparam int DM_DATA_W = 32;

endpackage : dm_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter (combinational).
//               A lone requester always wins; on a tie the port that did not
//               win most recently is granted.
// Ports       : req[1:0]   in  - per-port request
//               last       in  - index of the most recently granted port
//               grant[1:0] out - one-hot grant (all zero when idle)
//               valid      out - at least one port requests
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dm_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       valid
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = 2'b00;
            if (last) begin
                grant[PORT_CPU] = 1'b1;
            end else begin
                grant[PORT_IO]  = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_port_arbiter
// Description : Shares the single-ported data memory between the CPU
//               load/store unit (port 0) and the I/O/DMA engine (port 1).
//               One word access at a time: arbitrate, strobe the memory,
//               capture read data, then pulse a one-cycle acknowledge.
// Ports       : clk, reset_n          - clock, async active-low reset
//               req/wr[1:0]           - per-port request and op (1 = write)
//               addr0/1, wdata0/1     - per-port address and write data
//               ack[1:0], err, rdata  - completion pulse, status, read word
//               dm_cs/dm_rd/dm_wr     - memory strobes
//               dm_addr, dm_din       - memory address and write data
//               dm_dout, mrdy         - memory read data and read-ready
// Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter
    import dm_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req,
    input  logic [1:0]           wr,
    input  logic [DM_ADDR_W-1:0] addr0,
    input  logic [DM_ADDR_W-1:0] addr1,
    input  logic [DM_DATA_W-1:0] wdata0,
    input  logic [DM_DATA_W-1:0] wdata1,
    output logic [1:0]           ack,
    output logic                 err,
    output logic [DM_DATA_W-1:0] rdata,
    output logic                 dm_cs,
    output logic                 dm_rd,
    output logic                 dm_wr,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [DM_DATA_W-1:0] dm_din,
    input  logic [DM_DATA_W-1:0] dm_dout,
    input  logic                 mrdy
);

    // Counter value seen in the last ACCESS cycle before a read gives up.
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;
    logic                 r_port;
    logic                 r_wr;
    logic                 r_err;
    logic [7:0]           r_tcnt;
    logic [DM_ADDR_W-1:0] r_addr;
    logic [DM_DATA_W-1:0] r_wdata;
    logic [DM_DATA_W-1:0] r_rdata;

    logic [1:0]           w_grant;
    logic                 w_gnt_valid;
    logic                 w_gnt_port;
    logic [DM_ADDR_W-1:0] w_sel_addr;
    logic [DM_DATA_W-1:0] w_sel_wdata;
    logic                 w_sel_wr;
    logic                 w_misaligned;
    logic                 w_latch;
    logic                 w_rd_capture;
    logic                 w_timeout;

    rr_arb2 u_arb (
        .req   (req),
        .last  (r_last),
        .grant (w_grant),
        .valid (w_gnt_valid)
    );

    assign w_gnt_port   = w_grant[PORT_IO];
    assign w_sel_addr   = w_grant[PORT_CPU] ? addr0  : addr1;
    assign w_sel_wdata  = w_grant[PORT_CPU] ? wdata0 : wdata1;
    assign w_sel_wr     = w_grant[PORT_CPU] ? wr[PORT_CPU] : wr[PORT_IO];
    assign w_misaligned = |w_sel_addr[1:0];

    // Next-state and sequencing decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_rd_capture = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_latch     = 1'b1;
                    // Misaligned accesses never touch the memory.
                    w_state_nxt = w_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (r_wr) begin
                    w_state_nxt = RESP;
                end else if (mrdy) begin
                    w_rd_capture = 1'b1;
                    w_state_nxt  = RESP;
                end else if (r_tcnt >= c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode from state so that an asynchronous reset drops the
    // strobes immediately, before any clock edge.
    always_comb begin
        dm_cs   = (r_state == ACCESS);
        dm_rd   = (r_state == ACCESS) && !r_wr;
        dm_wr   = (r_state == ACCESS) &&  r_wr;
        dm_addr = (r_state == IDLE) ? '0 : r_addr;
        dm_din  = (r_state == IDLE) ? '0 : r_wdata;
        ack     = 2'b00;
        err     = 1'b0;
        if (r_state == RESP) begin
            ack[r_port] = 1'b1;
            err         = r_err;
        end
    end

    assign rdata = r_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_tcnt  <= 8'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_port  <= w_gnt_port;
                r_last  <= w_gnt_port;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_wr    <= w_sel_wr;
                r_err   <= w_misaligned;
                r_tcnt  <= 8'd0;
            end
            // Saturating wait counter for reads stalled on mrdy.
            if ((r_state == ACCESS) && !r_wr && !mrdy && (r_tcnt != 8'hFF)) begin
                r_tcnt <= r_tcnt + 8'd1;
            end
            if (w_rd_capture) begin
                r_rdata <= dm_dout;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule : dm_port_arbiter
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_port_arbiter
// Description : Directed self-checking bench for dm_port_arbiter with a
//               behavioural 4 KB word memory and a programmable mrdy delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req     = 2'b00;
    logic [1:0]  wr      = 2'b00;
    logic [31:0] addr0   = '0;
    logic [31:0] addr1   = '0;
    logic [31:0] wdata0  = '0;
    logic [31:0] wdata1  = '0;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic        dm_cs;
    logic        dm_rd;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [31:0] dm_dout;
    logic        mrdy;

    int checks    = 0;
    int errors    = 0;
    int both_bad  = 0;

    logic        preload    = 1'b0;
    int          mrdy_delay = 0;
    logic        mrdy_never = 1'b0;
    int          rd_cnt;
    logic [31:0] mem [0:1023];

    dm_port_arbiter #(.TIMEOUT(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .wr      (wr),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack     (ack),
        .err     (err),
        .rdata   (rdata),
        .dm_cs   (dm_cs),
        .dm_rd   (dm_rd),
        .dm_wr   (dm_wr),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_dout (dm_dout),
        .mrdy    (mrdy)
    );

    always #5 clk = ~clk;

    // Behavioural memory: word write committed at the edge closing the
    // strobe cycle, combinational read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[8] <= 32'hCAFEF00D;
        end else if (dm_cs && dm_wr) begin
            mem[dm_addr[11:2]] <= dm_din;
        end
    end
    assign dm_dout = mem[dm_addr[11:2]];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)   rd_cnt <= 0;
        else if (dm_rd) rd_cnt <= rd_cnt + 1;
        else            rd_cnt <= 0;
    end
    assign mrdy = dm_rd && !mrdy_never && (rd_cnt >= mrdy_delay);

    always @(negedge clk) if (dm_rd && dm_wr) both_bad++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on port p; cycle 0 is the IDLE cycle this is called in.
    task automatic single(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int cyc, output logic e,
                          output logic [31:0] rd, output int ncs, output int nrd,
                          output int nwr, output logic [31:0] sa);
        cyc = 0; ncs = 0; nrd = 0; nwr = 0; e = 1'bx; rd = 'x; sa = 'x;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        wr[p]  = w;
        req[p] = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (dm_cs) begin ncs++; sa = dm_addr; end
            if (dm_rd) nrd++;
            if (dm_wr) nwr++;
            if (ack[p]) begin cyc = i; e = err; rd = rdata; break; end
        end
        req[p] = 1'b0;
        tick();
    endtask

    // Both ports request in the same IDLE cycle.
    task automatic dual(input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        output int c0, output int c1, output logic [31:0] rd0);
        c0 = 0; c1 = 0; rd0 = 'x;
        addr0 = a0; wdata0 = d0; addr1 = a1; wdata1 = d1;
        wr  = {w1, w0};
        req = 2'b11;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (ack[0]) begin c0 = i; rd0 = rdata; req[0] = 1'b0; end
            if (ack[1]) begin c1 = i; req[1] = 1'b0; end
            if (req == 2'b00) break;
        end
        req = 2'b00;
        tick();
    endtask

    int          cyc, ncs, nrd, nwr, c0, c1;
    logic        e;
    logic [31:0] rd, sa, rd0;

    // Streaming state
    int          n, p, last_p, last_ack_cyc, alt_bad, pulse_bad, rd_bad, err_bad;
    int          k [2];
    logic        op [2];
    logic [31:0] exp_data [2];

    task automatic set_port(input int q);
        logic [31:0] a, d;
        a = (q == 0 ? 32'h400 : 32'h800) + 32'(k[q] * 4);
        d = $urandom;
        if (op[q]) exp_data[q] = d;
        if (q == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        wr[q] = op[q];
    endtask

    initial begin
        preload = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset state
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", rdata,      32'd0);
        check("rst_strb",  32'({dm_cs, dm_rd, dm_wr}), 32'd0);
        check("rst_addr",  dm_addr,    32'd0);
        check("rst_din",   dm_din,     32'd0);
        reset_n = 1'b1;
        tick();

        // Single write then read on port 0
        single(0, 1'b1, 32'h010, 32'hDEADBEEF, cyc, e, rd, ncs, nrd, nwr, sa);
        check("wr_ack_cyc", 32'(cyc), 32'd2);
        check("wr_err",     32'(e),   32'd0);
        check("wr_pulses",  32'(nwr), 32'd1);
        check("wr_rd_strb", 32'(nrd), 32'd0);
        check("wr_addr",    sa,       32'h010);
        check("wr_mem",     mem[4],   32'hDEADBEEF);

        single(0, 1'b0, 32'h010, 32'h0, cyc, e, rd, ncs, nrd, nwr, sa);
        check("rd_ack_cyc", 32'(cyc), 32'd2);
        check("rd_err",     32'(e),   32'd0);
        check("rd_data",    rd,       32'hDEADBEEF);
        check("rd_pulses",  32'(nrd), 32'd1);

        // Read with mrdy delayed by 3 cycles on port 1
        mrdy_delay = 3;
        single(1, 1'b0, 32'h020, 32'h0, cyc, e, rd, ncs, nrd, nwr, sa);
        mrdy_delay = 0;
        check("dly_ack_cyc", 32'(cyc), 32'd5);
        check("dly_data",    rd,       32'hCAFEF00D);
        check("dly_rd_cyc",  32'(nrd), 32'd4);

        // Simultaneous requests right after reset
        reset_n = 1'b0; #2; reset_n = 1'b1;
        tick();
        dual(1'b0, 32'h020, 32'h0, 1'b1, 32'h024, 32'h11223344, c0, c1, rd0);
        check("tie1_ack0", 32'(c0), 32'd2);
        check("tie1_ack1", 32'(c1), 32'd5);
        check("tie1_rd",   rd0,     32'hCAFEF00D);
        check("tie1_mem",  mem[9],  32'h11223344);
        dual(1'b0, 32'h020, 32'h0, 1'b1, 32'h024, 32'h55667788, c0, c1, rd0);
        check("tie2_ack0", 32'(c0), 32'd2);
        check("tie2_ack1", 32'(c1), 32'd5);

        // After a port-0 grant, a tie goes to port 1
        single(0, 1'b0, 32'h020, 32'h0, cyc, e, rd, ncs, nrd, nwr, sa);
        dual(1'b0, 32'h020, 32'h0, 1'b1, 32'h024, 32'h99AABBCC, c0, c1, rd0);
        check("tie3_ack1", 32'(c1), 32'd2);
        check("tie3_ack0", 32'(c0), 32'd5);

        // Misaligned read on port 1 and misaligned write on port 0
        single(1, 1'b0, 32'h0000_0102, 32'h0, cyc, e, rd, ncs, nrd, nwr, sa);
        check("mis_ack_cyc", 32'(cyc), 32'd1);
        check("mis_err",     32'(e),   32'd1);
        check("mis_cs",      32'(ncs), 32'd0);
        check("mis_rdata",   rd,       32'hCAFEF00D);
        single(0, 1'b1, 32'h0000_0013, 32'h12345678, cyc, e, rd, ncs, nrd, nwr, sa);
        check("misw_ack_cyc", 32'(cyc), 32'd1);
        check("misw_err",     32'(e),   32'd1);
        check("misw_wr",      32'(nwr), 32'd0);

        // Read timeout
        mrdy_never = 1'b1;
        single(0, 1'b0, 32'h010, 32'h0, cyc, e, rd, ncs, nrd, nwr, sa);
        mrdy_never = 1'b0;
        check("to_ack_cyc", 32'(cyc), 32'd16);
        check("to_err",     32'(e),   32'd1);
        check("to_rd_cyc",  32'(nrd), 32'd15);
        check("to_rdata",   rd,       32'hCAFEF00D);
        single(0, 1'b0, 32'h010, 32'h0, cyc, e, rd, ncs, nrd, nwr, sa);
        check("post_to_err",  32'(e), 32'd0);
        check("post_to_data", rd,     32'hDEADBEEF);

        // Reset during a write access
        addr0 = 32'h030; wdata0 = 32'h55AA55AA; wr[0] = 1'b1; req[0] = 1'b1;
        tick();
        check("mid_wr_active", 32'(dm_wr), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_strb", 32'({dm_cs, dm_rd, dm_wr}), 32'd0);
        check("async_ack",  32'(ack), 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_mem", mem[12], 32'd0);
        reset_n = 1'b1;
        tick();
        dual(1'b0, 32'h030, 32'h0, 1'b1, 32'h034, 32'h0BADF00D, c0, c1, rd0);
        check("rst_tie_ack0", 32'(c0), 32'd2);
        check("rst_tie_ack1", 32'(c1), 32'd5);
        check("rst_tie_rd",   rd0,     32'd0);

        // Streaming: both ports alternate write/read for 100 accesses
        n = 0; last_p = -1; last_ack_cyc = -10;
        alt_bad = 0; pulse_bad = 0; rd_bad = 0; err_bad = 0;
        k[0] = 0; k[1] = 0; op[0] = 1'b1; op[1] = 1'b1;
        set_port(0); set_port(1);
        req = 2'b11;
        for (int c = 1; c <= 600 && n < 100; c++) begin
            tick();
            if (ack != 2'b00) begin
                p = ack[1] ? 1 : 0;
                if (ack == 2'b11)          alt_bad++;
                if (c == last_ack_cyc + 1) pulse_bad++;
                if (p == last_p)           alt_bad++;
                if (err)                   err_bad++;
                if (!op[p] && (rdata !== exp_data[p])) rd_bad++;
                if (!op[p]) k[p]++;
                op[p] = !op[p];
                last_p = p; last_ack_cyc = c; n++;
                set_port(p);
            end
        end
        req = 2'b00;
        tick(); tick();
        check("strm_count",   32'(n),            32'd100);
        check("strm_last",    32'(last_ack_cyc), 32'd299);
        check("strm_alt",     32'(alt_bad),      32'd0);
        check("strm_pulse",   32'(pulse_bad),    32'd0);
        check("strm_rdata",   32'(rd_bad),       32'd0);
        check("strm_err",     32'(err_bad),      32'd0);
        check("rd_wr_excl",   32'(both_bad),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_dm_port_arbiter
`default_nettype wire
